// File: rtl/adder_pkg.sv
// Shared constants and carry-lookahead helpers for the adder datapath.
package adder_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    localparam int CLA_GROUP      = 4;
    localparam int CLA_MAX_GROUPS = 16;

    // Sum-of-products carry into position n, given propagate/generate of positions 0..n-1.
    function automatic logic lookahead_carry(input logic [15:0] p, input logic [15:0] g,
                                             input logic cin, input int n);
        logic acc;
        logic prop;
        acc  = 1'b0;
        prop = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            if (k < n) begin
                acc  = acc | (prop & g[k]);
                prop = prop & p[k];
            end
        end
        return acc | (prop & cin);
    endfunction

endpackage

// File: rtl/adder_full_adder.sv
// One-bit full adder cell exposing its propagate/generate terms for lookahead logic.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout,
    output logic p,
    output logic g
);

    assign p    = a ^ b;
    assign g    = a & b;
    assign s    = p ^ cin;
    assign cout = g | (p & cin);

endmodule

// File: rtl/adder.sv
// Two's-complement adder/subtractor with combinational sum and a registered {N,Z,C,V} flag bank.
// Define ADDER_CLA_EN for a 4-bit-group carry-lookahead chain; otherwise a ripple chain is built.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [3:0]       flags_q
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] beff;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic [3:0]       flags_d;

    assign beff = (M == SUB) ? ~B : B;

`ifdef ADDER_CLA_EN
    localparam int NUM_GROUPS = (WIDTH + CLA_GROUP - 1) / CLA_GROUP;

    logic [WIDTH-1:0]      p_vec;
    logic [WIDTH-1:0]      g_vec;
    logic [WIDTH-1:0]      unused_cout;
    logic [NUM_GROUPS-1:0] gp_vec;
    logic [NUM_GROUPS-1:0] gg_vec;
    logic [15:0]           gp_ext;
    logic [15:0]           gg_ext;
    logic [NUM_GROUPS:0]   group_cin;

    always_comb begin
        gp_ext = '0;
        gg_ext = '0;
        gp_ext[NUM_GROUPS-1:0] = gp_vec;
        gg_ext[NUM_GROUPS-1:0] = gg_vec;
    end

    // Every group carry is an independent lookahead over all lower groups.
    for (genvar j = 0; j <= NUM_GROUPS; j++) begin : g_grp_carry
        assign group_cin[j] = lookahead_carry(gp_ext, gg_ext, M, j);
    end

    for (genvar j = 0; j < NUM_GROUPS; j++) begin : g_group
        localparam int BASE = j * CLA_GROUP;
        localparam int SIZE = (WIDTH - BASE >= CLA_GROUP) ? CLA_GROUP : WIDTH - BASE;

        logic [15:0] p_loc;
        logic [15:0] g_loc;

        always_comb begin
            p_loc = '0;
            g_loc = '0;
            p_loc[SIZE-1:0] = p_vec[BASE +: SIZE];
            g_loc[SIZE-1:0] = g_vec[BASE +: SIZE];
        end

        assign gg_vec[j] = lookahead_carry(p_loc, g_loc, 1'b0, SIZE);
        assign gp_vec[j] = &p_vec[BASE +: SIZE];

        for (genvar k = 0; k < SIZE; k++) begin : g_bit
            full_adder u_fa (
                .a    (A[BASE+k]),
                .b    (beff[BASE+k]),
                .cin  (lookahead_carry(p_loc, g_loc, group_cin[j], k)),
                .s    (sum[BASE+k]),
                .cout (unused_cout[BASE+k]),
                .p    (p_vec[BASE+k]),
                .g    (g_vec[BASE+k])
            );
        end
    end

    assign carry_out = group_cin[NUM_GROUPS];
`else
    // Carries live in per-bit generate scopes so each link of the chain is its own net.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic carry_in;
        logic carry_o;
        logic unused_p;
        logic unused_g;

        if (i == 0) begin : g_lsb
            assign carry_in = M;
        end else begin : g_chain
            assign carry_in = g_bit[i-1].carry_o;
        end

        full_adder u_fa (
            .a    (A[i]),
            .b    (beff[i]),
            .cin  (carry_in),
            .s    (sum[i]),
            .cout (carry_o),
            .p    (unused_p),
            .g    (unused_g)
        );
    end

    assign carry_out = g_bit[WIDTH-1].carry_o;
`endif

    assign S    = sum;
    assign Cout = carry_out;

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = sum[MSB];
        flags_d[FLAG_Z] = (sum == '0);
        flags_d[FLAG_C] = carry_out;
        flags_d[FLAG_V] = (A[MSB] == beff[MSB]) && (sum[MSB] != A[MSB]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed corner cases plus random vectors against an arithmetic model.
module tb_adder;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         M;
    logic [W-1:0] S;
    logic         Cout;
    logic [3:0]   flags_q;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .M       (M),
        .S       (S),
        .Cout    (Cout),
        .flags_q (flags_q)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic [3:0]   flags;
    } ref_t;

    // Plain wide arithmetic: unsigned carry/borrow and signed overflow via one extra sign bit.
    function automatic ref_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        ref_t       r;
        logic [W:0] u;
        logic [W:0] sx;
        logic       v;
        if (!m) begin
            u      = {1'b0, a} + {1'b0, b};
            r.s    = u[W-1:0];
            r.cout = u[W];
            sx     = {a[W-1], a} + {b[W-1], b};
        end else begin
            r.s    = a - b;
            r.cout = (a >= b);
            sx     = {a[W-1], a} - {b[W-1], b};
        end
        v       = sx[W] ^ sx[W-1];
        r.flags = {r.s[W-1], (r.s == '0), r.cout, v};
        return r;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            4:       return W'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input logic r);
        @(negedge clk);
        A   = a;
        B   = b;
        M   = m;
        rst = r;
        #1;
    endtask

    task automatic test_reset();
        drive(64'd5, 64'd7, 1'b0, 1'b1);
        n_checks++;
        if (S !== 64'd12) $display("[TB] FAIL reset_sum_comb: got %h expected %h", S, 64'd12);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (flags_q !== 4'b0000) $display("[TB] FAIL reset_flags[%0d]: got %b expected 0000", i, flags_q);
            else n_pass++;
            n_checks++;
            if (S !== 64'd12) $display("[TB] FAIL reset_sum[%0d]: got %h expected %h", i, S, 64'd12);
            else n_pass++;
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic         tm [5];
        logic [W-1:0] ts [5];
        logic         tc [5];
        logic [3:0]   tf [5];
        ta[0] = 64'd8;                  tb[0] = 64'd1;      tm[0] = 1'b0;
        ts[0] = 64'd9;                  tc[0] = 1'b0;       tf[0] = 4'b0000;
        ta[1] = 64'h1234;               tb[1] = 64'h1234;   tm[1] = 1'b1;
        ts[1] = 64'd0;                  tc[1] = 1'b1;       tf[1] = 4'b0110;
        ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tb[2] = 64'd1;      tm[2] = 1'b0;
        ts[2] = 64'd0;                  tc[2] = 1'b1;       tf[2] = 4'b0110;
        ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb[3] = 64'd1;      tm[3] = 1'b0;
        ts[3] = 64'h8000_0000_0000_0000; tc[3] = 1'b0;       tf[3] = 4'b1001;
        ta[4] = 64'd3;                  tb[4] = 64'd5;      tm[4] = 1'b1;
        ts[4] = 64'hFFFF_FFFF_FFFF_FFFE; tc[4] = 1'b0;       tf[4] = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            drive(ta[i], tb[i], tm[i], 1'b0);
            n_checks++;
            if (S !== ts[i]) $display("[TB] FAIL directed_sum[%0d]: got %h expected %h", i, S, ts[i]);
            else n_pass++;
            n_checks++;
            if (Cout !== tc[i]) $display("[TB] FAIL directed_cout[%0d]: got %b expected %b", i, Cout, tc[i]);
            else n_pass++;
            @(posedge clk);
            #1;
            n_checks++;
            if (flags_q !== tf[i]) $display("[TB] FAIL directed_flags[%0d]: got %b expected %b", i, flags_q, tf[i]);
            else n_pass++;
        end
    endtask

    // Reset must beat a flag-producing sample, and the first released edge captures live operands.
    task automatic test_reset_midstream();
        ref_t exp;
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        exp = ref_model(A, B, M);
        @(posedge clk);
        #1;
        n_checks++;
        if (flags_q !== exp.flags) $display("[TB] FAIL midstream_pre: got %b expected %b", flags_q, exp.flags);
        else n_pass++;
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        n_checks++;
        if (flags_q !== 4'b0000) $display("[TB] FAIL midstream_rst_wins: got %b expected 0000", flags_q);
        else n_pass++;
        drive(64'd3, 64'd5, 1'b1, 1'b0);
        exp = ref_model(A, B, M);
        @(posedge clk);
        #1;
        n_checks++;
        if (flags_q !== exp.flags) $display("[TB] FAIL midstream_release: got %b expected %b", flags_q, exp.flags);
        else n_pass++;
    endtask

    task automatic test_random();
        ref_t         exp;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        for (int i = 0; i < 10000; i++) begin
            a = pick_operand();
            b = pick_operand();
            m = 1'($urandom_range(0, 1));
            drive(a, b, m, 1'b0);
            exp = ref_model(a, b, m);
            n_checks++;
            if (S !== exp.s) begin
                if (n_checks - n_pass < 20)
                    $display("[TB] FAIL random_sum[%0d]: a=%h b=%h m=%b got %h expected %h", i, a, b, m, S, exp.s);
            end else n_pass++;
            n_checks++;
            if (Cout !== exp.cout) begin
                if (n_checks - n_pass < 20)
                    $display("[TB] FAIL random_cout[%0d]: a=%h b=%h m=%b got %b expected %b", i, a, b, m, Cout, exp.cout);
            end else n_pass++;
            @(posedge clk);
            #1;
            n_checks++;
            if (flags_q !== exp.flags) begin
                if (n_checks - n_pass < 20)
                    $display("[TB] FAIL random_flags[%0d]: a=%h b=%h m=%b got %b expected %b", i, a, b, m, flags_q, exp.flags);
            end else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        A   = '0;
        B   = '0;
        M   = 1'b0;
        test_reset();
        test_directed();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
